// File: rtl/mult_min_scheduler_if.sv
// mult_min_scheduler_if
//   Bus between the scheduler and one shared mult_and_min unit.
//   master : scheduler side  (drives mm_start, mm_inA/B/C; receives mm_ready/overflow/result)
//   slave  : unit side       (the reverse)
//   Parameter n: operand/result width.
interface mult_min_scheduler_if #(
    parameter int n = 8
);
    logic         mm_start;
    logic [n-1:0] mm_inA;
    logic [n-1:0] mm_inB;
    logic [n-1:0] mm_inC;
    logic         mm_ready;
    logic         mm_overflow;
    logic [n-1:0] mm_result;

    modport master (
        output mm_start, mm_inA, mm_inB, mm_inC,
        input  mm_ready, mm_overflow, mm_result
    );

    modport slave (
        input  mm_start, mm_inA, mm_inB, mm_inC,
        output mm_ready, mm_overflow, mm_result
    );
endinterface

// File: rtl/mult_min_scheduler.sv
// mult_min_scheduler
//   Shares one mult_and_min unit among NREQ requesters. Each requester owns a 1-deep
//   pending slot; a round-robin FSM (IDLE->LAUNCH->SETTLE->WAIT->RESP) launches one slot
//   at a time and returns result/overflow tagged with the requester id.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req/req_a/b/c       per-requester post strobe and operands (slot i = [i*n +: n])
//   pend                slot occupied (accepted, not yet completed)
//   done/done_id        one-cycle completion pulse and requester id
//   res/ovf/err         result, overflow, timeout abort (valid with done, held after)
//   mm                  master side of mult_min_scheduler_if toward the unit
// Configuration
//   MMS_TIMEOUT_EN      when defined, WAIT aborts after TIMEOUT_CYCLES without mm_ready
//                       and completes with err=1, res=0, ovf=0. Otherwise err is 0.
module mult_min_scheduler #(
    parameter int n              = 8,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int IDW           = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*n-1:0]     req_a,
    input  logic [NREQ*n-1:0]     req_b,
    input  logic [NREQ*n-1:0]     req_c,
    output logic [NREQ-1:0]       pend,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [n-1:0]          res,
    output logic                  ovf,
    output logic                  err,
    mult_min_scheduler_if.master  mm
);
    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_SETTLE, S_WAIT, S_RESP} state_t;

    state_t                 state, state_nxt;
    logic [NREQ-1:0][n-1:0] slot_a, slot_b, slot_c;
    logic [IDW-1:0]         rr, cur_id, pick;
    logic                   found, tmo_hit;

    logic                   start_nxt, done_nxt, ovf_nxt, err_nxt;
    logic [n-1:0]           in_a_nxt, in_b_nxt, in_c_nxt, res_nxt;
    logic [IDW-1:0]         cur_id_nxt, done_id_nxt;

    // First occupied slot at or after the round-robin pointer.
    always_comb begin : pick_blk
        int idx;
        idx   = 0;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && pend[idx]) begin
                pick  = IDW'(idx);
                found = 1'b1;
            end
        end
    end

`ifdef MMS_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Zero outside WAIT, so it restarts on every WAIT entry.
    always_ff @(posedge clk) begin
        if (reset || state != S_WAIT) tmo_cnt <= '0;
        else                          tmo_cnt <= tmo_cnt + 16'd1;
    end

    assign tmo_hit = (state == S_WAIT) && (tmo_cnt >= 16'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    // Slot capture, slot release and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
            rr   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && !pend[i]) begin
                    pend[i]   <= 1'b1;
                    slot_a[i] <= req_a[i*n +: n];
                    slot_b[i] <= req_b[i*n +: n];
                    slot_c[i] <= req_c[i*n +: n];
                end
            end
            // pend stays high through the done cycle, so a re-post then is dropped.
            if (state == S_RESP) begin
                pend[cur_id] <= 1'b0;
                rr           <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (found) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_SETTLE;
            // A stale ready from the previous op may still be high here.
            S_SETTLE: state_nxt = S_WAIT;
            S_WAIT:   if (mm.mm_ready || tmo_hit) state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs, computed one cycle ahead and registered below.
    always_comb begin
        start_nxt   = 1'b0;
        done_nxt    = 1'b0;
        in_a_nxt    = mm.mm_inA;
        in_b_nxt    = mm.mm_inB;
        in_c_nxt    = mm.mm_inC;
        cur_id_nxt  = cur_id;
        done_id_nxt = done_id;
        res_nxt     = res;
        ovf_nxt     = ovf;
        err_nxt     = err;
        case (state)
            S_IDLE: if (found) begin
                start_nxt  = 1'b1;
                in_a_nxt   = slot_a[pick];
                in_b_nxt   = slot_b[pick];
                in_c_nxt   = slot_c[pick];
                cur_id_nxt = pick;
            end
            S_WAIT: if (mm.mm_ready) begin
                done_nxt    = 1'b1;
                done_id_nxt = cur_id;
                res_nxt     = mm.mm_result;
                ovf_nxt     = mm.mm_overflow;
                err_nxt     = 1'b0;
            end else if (tmo_hit) begin
                done_nxt    = 1'b1;
                done_id_nxt = cur_id;
                res_nxt     = '0;
                ovf_nxt     = 1'b0;
                err_nxt     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mm.mm_start <= 1'b0;
            mm.mm_inA   <= '0;
            mm.mm_inB   <= '0;
            mm.mm_inC   <= '0;
            cur_id      <= '0;
            done        <= 1'b0;
            done_id     <= '0;
            res         <= '0;
            ovf         <= 1'b0;
            err         <= 1'b0;
        end else begin
            mm.mm_start <= start_nxt;
            mm.mm_inA   <= in_a_nxt;
            mm.mm_inB   <= in_b_nxt;
            mm.mm_inC   <= in_c_nxt;
            cur_id      <= cur_id_nxt;
            done        <= done_nxt;
            done_id     <= done_id_nxt;
            res         <= res_nxt;
            ovf         <= ovf_nxt;
            err         <= err_nxt;
        end
    end
endmodule
